// File: rtl/dbg_bridge.sv
// Serial debug bridge: turns UART command bytes into single-byte bus reads/writes
// and halt control, replying one byte per command on the UART transmit side.
module dbg_bridge #(
    parameter int READ_WAIT = 1,
    parameter int TIMEOUT   = 20800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] address,
    output logic [7:0]  dout,
    input  logic [7:0]  din,
    output logic        read,
    output logic        halt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] CMD_N   = 8'h4E;
    localparam logic [7:0] CMD_H   = 8'h48;
    localparam logic [7:0] CMD_G   = 8'h47;
    localparam logic [7:0] RPL_OK  = 8'h4B;
    localparam logic [7:0] RPL_BAD = 8'h3F;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARG_AH = 3'd1,
        ARG_AL = 3'd2,
        ARG_D  = 3'd3,
        REQ    = 3'd4,
        ACCESS = 3'd5,
        RESP   = 3'd6
    } state_t;

    state_t          state_r;
    logic            is_write_r;
    logic [7:0]      ah_r;
    logic [7:0]      al_r;
    logic [7:0]      data_r;
    logic [15:0]     addr_r;
    logic [TW-1:0]   tmo_r;
    logic [AW-1:0]   acc_cnt_r;

    // Command sequencer: decode, argument collection with timeout, bus access, reply
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            is_write_r <= 1'b0;
            ah_r       <= 8'h00;
            al_r       <= 8'h00;
            data_r     <= 8'h00;
            addr_r     <= 16'h0000;
            tmo_r      <= '0;
            acc_cnt_r  <= '0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            bus_req    <= 1'b0;
            address    <= 16'h0000;
            dout       <= 8'h00;
            read       <= 1'b1;
            halt       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    tmo_r <= '0;
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_W: begin
                                is_write_r <= 1'b1;
                                state_r    <= ARG_AH;
                            end
                            CMD_R: begin
                                is_write_r <= 1'b0;
                                state_r    <= ARG_AH;
                            end
                            CMD_N: begin
                                is_write_r <= 1'b0;
                                addr_r     <= addr_r + 16'd1;
                                bus_req    <= 1'b1;
                                state_r    <= REQ;
                            end
                            CMD_H: begin
                                halt     <= 1'b1;
                                tx_data  <= RPL_OK;
                                tx_valid <= 1'b1;
                                state_r  <= RESP;
                            end
                            CMD_G: begin
                                halt     <= 1'b0;
                                tx_data  <= RPL_OK;
                                tx_valid <= 1'b1;
                                state_r  <= RESP;
                            end
                            default: begin
                                tx_data  <= RPL_BAD;
                                tx_valid <= 1'b1;
                                state_r  <= RESP;
                            end
                        endcase
                    end
                end
                ARG_AH, ARG_AL, ARG_D: begin
                    if (rx_valid) begin
                        tmo_r <= '0;
                        if (state_r == ARG_AH) begin
                            ah_r    <= rx_data;
                            state_r <= ARG_AL;
                        end else if (state_r == ARG_AL) begin
                            al_r <= rx_data;
                            if (is_write_r) begin
                                state_r <= ARG_D;
                            end else begin
                                addr_r  <= {ah_r, rx_data};
                                bus_req <= 1'b1;
                                state_r <= REQ;
                            end
                        end else begin
                            data_r  <= rx_data;
                            addr_r  <= {ah_r, al_r};
                            bus_req <= 1'b1;
                            state_r <= REQ;
                        end
                    end else if (tmo_r == TW'(TIMEOUT - 1)) begin
                        // Abandoned command: latched address is only committed on REQ entry
                        tmo_r   <= '0;
                        state_r <= IDLE;
                    end else begin
                        tmo_r <= tmo_r + TW'(1);
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        address   <= addr_r;
                        acc_cnt_r <= '0;
                        read      <= ~is_write_r;
                        if (is_write_r) begin
                            dout <= data_r;
                        end
                        state_r <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!bus_gnt) begin
                        read    <= 1'b1;
                        state_r <= REQ;
                    end else if (is_write_r) begin
                        read     <= 1'b1;
                        bus_req  <= 1'b0;
                        tx_data  <= RPL_OK;
                        tx_valid <= 1'b1;
                        state_r  <= RESP;
                    end else if (acc_cnt_r == AW'(READ_WAIT)) begin
                        bus_req  <= 1'b0;
                        tx_data  <= din;
                        tx_valid <= 1'b1;
                        state_r  <= RESP;
                    end else begin
                        acc_cnt_r <= acc_cnt_r + AW'(1);
                    end
                end
                RESP: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_bridge.sv
// Self-checking bench for dbg_bridge: directed scenarios plus randomized command
// streams checked against a command-level model with a sparse memory image.
module tb_dbg_bridge;

    localparam int TIMEOUT = 20800;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] address;
    logic [7:0]  dout;
    logic [7:0]  din;
    logic        read;
    logic        halt;

    int check_cnt = 0;
    int err_cnt   = 0;

    logic [7:0]  reply_q[$];
    logic [23:0] wr_q[$];
    logic        req_seen;
    logic        rand_mode;
    logic        env_clr;

    logic [7:0]  model_wr [logic [15:0]];
    logic [15:0] model_addr;
    logic        model_halt;

    logic [7:0]  sram_w [0:65535];
    logic        sram_v [0:65535];

    dbg_bridge #(.READ_WAIT(1), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .address  (address),
        .dout     (dout),
        .din      (din),
        .read     (read),
        .halt     (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] base_byte(input logic [15:0] a);
        return (a[15:8] * 8'd7) ^ a[7:0] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] model_rd(input logic [15:0] a);
        if (model_wr.exists(a)) return model_wr[a];
        return base_byte(a);
    endfunction

    // Synchronous SRAM: one-cycle read latency, write on read=0 while granted
    always @(posedge clk) begin
        if (env_clr) begin
            for (int i = 0; i < 65536; i++) sram_v[i] <= 1'b0;
        end else if (bus_gnt && !read) begin
            sram_w[address] <= dout;
            sram_v[address] <= 1'b1;
        end
        din <= sram_v[address] ? sram_w[address] : base_byte(address);
    end

    // Observe handshakes and bus writes mid-cycle, before the edge that commits them
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (tx_valid && tx_ready) reply_q.push_back(tx_data);
            if (bus_gnt && !read) wr_q.push_back({address, dout});
            if (bus_req) req_seen = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_mode) begin
                bus_gnt  = ($urandom_range(0, 9) != 0);
                tx_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_reply(input int limit);
        for (int i = 0; i < limit && reply_q.size() == 0; i++) @(posedge clk);
    endtask

    task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] ah, input logic [7:0] al,
                           input logic [7:0] d, input int last_gap, input string tag);
        logic [7:0]  exp;
        logic [7:0]  args [3];
        int          nargs;
        logic        exp_wr;
        logic        uses_bus;
        logic [15:0] exp_a;
        args[0]  = ah;
        args[1]  = al;
        args[2]  = d;
        exp_wr   = 1'b0;
        uses_bus = 1'b1;
        exp_a    = 16'h0000;
        nargs    = 0;
        case (cmd)
            8'h57: begin
                nargs = 3; exp_a = {ah, al}; model_addr = exp_a;
                model_wr[exp_a] = d; exp = 8'h4B; exp_wr = 1'b1;
            end
            8'h52: begin
                nargs = 2; model_addr = {ah, al}; exp = model_rd(model_addr);
            end
            8'h4E: begin
                model_addr = model_addr + 16'd1; exp = model_rd(model_addr);
            end
            8'h48: begin model_halt = 1'b1; exp = 8'h4B; uses_bus = 1'b0; end
            8'h47: begin model_halt = 1'b0; exp = 8'h4B; uses_bus = 1'b0; end
            default: begin exp = 8'h3F; uses_bus = 1'b0; end
        endcase
        reply_q.delete();
        wr_q.delete();
        req_seen = 1'b0;
        send_byte(cmd);
        for (int i = 0; i < nargs; i++) begin
            if (i == nargs - 1) repeat (last_gap - 1) @(negedge clk);
            send_byte(args[i]);
        end
        wait_reply(3000);
        check_eq({tag, "_reply_cnt"}, reply_q.size(), 1);
        if (reply_q.size() > 0) check_eq({tag, "_reply"}, reply_q[0], exp);
        check_eq({tag, "_halt"}, halt, model_halt);
        check_eq({tag, "_req"}, req_seen, uses_bus);
        check_eq({tag, "_wr_cnt"}, wr_q.size(), exp_wr ? 1 : 0);
        if (exp_wr && wr_q.size() > 0) check_eq({tag, "_wr"}, wr_q[0], {exp_a, d});
    endtask

    initial begin
        logic [7:0] c, ah, al, d;
        int         sel;

        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; bus_gnt = 1'b0;
        rand_mode = 1'b0; env_clr = 1'b1; req_seen = 1'b0;
        model_addr = 16'h0000; model_halt = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_tx_valid", tx_valid, 1'b0);
        check_eq("rst_bus_req", bus_req, 1'b0);
        check_eq("rst_address", address, 16'h0000);
        check_eq("rst_dout", dout, 8'h00);
        check_eq("rst_read", read, 1'b1);
        check_eq("rst_halt", halt, 1'b0);
        env_clr = 1'b0;
        @(negedge clk);
        rst = 1'b1; bus_gnt = 1'b1; tx_ready = 1'b1;
        @(negedge clk);

        run_cmd(8'h4E, 8'h00, 8'h00, 8'h00, 1, "n_after_rst");
        run_cmd(8'h57, 8'h00, 8'h10, 8'hA5, 1, "w_0010");
        run_cmd(8'h52, 8'h00, 8'h10, 8'h00, 1, "r_0010");
        run_cmd(8'h52, 8'hFF, 8'hFF, 8'h00, 1, "r_ffff");
        run_cmd(8'h4E, 8'h00, 8'h00, 8'h00, 1, "n_wrap");
        check_eq("n_wrap_addr", address, 16'h0000);

        // H latency: reply visible the cycle after the byte, gone after acceptance
        reply_q.delete();
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h48;
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        check_eq("h_lat_valid", tx_valid, 1'b1);
        check_eq("h_lat_data", tx_data, 8'h4B);
        @(negedge clk);
        #1;
        model_halt = 1'b1;
        check_eq("h_lat_drop", tx_valid, 1'b0);
        check_eq("h_lat_halt", halt, model_halt);
        check_eq("h_lat_cnt", reply_q.size(), 1);
        run_cmd(8'h47, 8'h00, 8'h00, 8'h00, 1, "g_cmd");
        run_cmd(8'h00, 8'h00, 8'h00, 8'h00, 1, "unknown");

        // Argument timeout: exactly TIMEOUT idle clocks aborts silently
        reply_q.delete(); wr_q.delete(); req_seen = 1'b0;
        send_byte(8'h57);
        send_byte(8'h12);
        repeat (TIMEOUT - 1) @(negedge clk);
        check_eq("tmo_no_reply", reply_q.size(), 0);
        check_eq("tmo_no_req", req_seen, 1'b0);
        run_cmd(8'h48, 8'h00, 8'h00, 8'h00, 1, "h_after_tmo");
        run_cmd(8'h4E, 8'h00, 8'h00, 8'h00, 1, "n_tmo_keep");
        run_cmd(8'h52, 8'h00, 8'h20, 8'h00, TIMEOUT - 1, "tmo_edge");

        // Grant withheld, then transmitter stalled; stray bytes must be dropped
        reply_q.delete(); wr_q.delete();
        @(negedge clk);
        bus_gnt = 1'b0; tx_ready = 1'b0;
        model_addr = 16'h0010;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h47);
        repeat (42) @(negedge clk);
        #1;
        check_eq("hold_req", bus_req, 1'b1);
        check_eq("hold_no_tx", tx_valid, 1'b0);
        check_eq("hold_halt", halt, model_halt);
        @(negedge clk);
        bus_gnt = 1'b1;
        for (int i = 0; i < 50 && !tx_valid; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq("hold_tx_up", tx_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx_valid = (i == 3);
            rx_data  = 8'h57;
            #1;
            check_eq("stall_valid", tx_valid, 1'b1);
            check_eq("stall_data", tx_data, model_rd(model_addr));
        end
        tx_ready = 1'b1;
        @(negedge clk);
        #1;
        check_eq("stall_drop", tx_valid, 1'b0);
        check_eq("stall_cnt", reply_q.size(), 1);
        if (reply_q.size() > 0) check_eq("stall_reply", reply_q[0], model_rd(16'h0010));
        check_eq("stall_no_wr", wr_q.size(), 0);
        run_cmd(8'h48, 8'h00, 8'h00, 8'h00, 1, "h_after_stall");

        // Randomized command stream with random grant and transmitter backpressure
        rand_mode = 1'b1;
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 6);
            case (sel)
                0: c = 8'h57;
                1: c = 8'h52;
                2, 3: c = 8'h4E;
                4: c = 8'h48;
                5: c = 8'h47;
                default: begin
                    c = 8'($urandom);
                    while (c == 8'h57 || c == 8'h52 || c == 8'h4E || c == 8'h48 || c == 8'h47)
                        c = 8'($urandom);
                end
            endcase
            case ($urandom_range(0, 2))
                0: ah = 8'h00;
                1: ah = 8'hFF;
                default: ah = 8'($urandom);
            endcase
            al = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
            d  = 8'($urandom);
            run_cmd(c, ah, al, d, $urandom_range(1, 4), "rand");
        end
        rand_mode = 1'b0;
        @(negedge clk);
        bus_gnt = 1'b1; tx_ready = 1'b1;

        // Reset in the middle of a write access must not complete the write
        @(negedge clk);
        bus_gnt = 1'b0;
        wr_q.delete();
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h30); send_byte(8'h77);
        repeat (3) @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        #1;
        check_eq("mid_acc_read", read, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_req", bus_req, 1'b0);
        check_eq("mid_rst_read", read, 1'b1);
        check_eq("mid_rst_tx", tx_valid, 1'b0);
        check_eq("mid_rst_halt", halt, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("mid_rst_no_wr", wr_q.size(), 0);
        rst = 1'b1;
        model_addr = 16'h0000; model_halt = 1'b0;
        run_cmd(8'h52, 8'h00, 8'h30, 8'h00, 1, "r_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
